// File: rtl/branch_resolve_if.sv
// ---------------------------------------------------------------------------
// branch_resolve_if
// Groups the decode-side handshake, operand/hazard inputs, next-stage
// handshake and fetch redirect of branch_resolve into one bundle.
//   slave  : the branch_resolve block (consumes decode/operands, drives results)
//   master : the surrounding pipeline (decode, hazard unit, next stage, fetch)
// Signals:
//   flush                     synchronous kill of the held instruction
//   in_valid/in_ready         decode handshake
//   in_op/in_pc/in_imm        decoded op (00 none, 01 BEQ, 10 BNE, 11 none), PC, word offset
//   rs_val/rt_val             forwarded operands, sampled live
//   rs_pend/rt_pend           operand not yet available
//   out_valid/out_ready       next-stage handshake
//   out_pc/out_taken/out_target  resolved instruction
//   redirect/redirect_pc      one-cycle fetch redirect
// ---------------------------------------------------------------------------
interface branch_resolve_if #(
    parameter int N   = 32,
    parameter int PCW = 32
);
    logic           flush;
    logic           in_valid;
    logic           in_ready;
    logic [1:0]     in_op;
    logic [PCW-1:0] in_pc;
    logic [15:0]    in_imm;
    logic [N-1:0]   rs_val;
    logic [N-1:0]   rt_val;
    logic           rs_pend;
    logic           rt_pend;
    logic           out_valid;
    logic           out_ready;
    logic [PCW-1:0] out_pc;
    logic           out_taken;
    logic [PCW-1:0] out_target;
    logic           redirect;
    logic [PCW-1:0] redirect_pc;

    modport master (
        output flush, in_valid, in_op, in_pc, in_imm,
        output rs_val, rt_val, rs_pend, rt_pend, out_ready,
        input  in_ready, out_valid, out_pc, out_taken, out_target,
        input  redirect, redirect_pc
    );

    modport slave (
        input  flush, in_valid, in_op, in_pc, in_imm,
        input  rs_val, rt_val, rs_pend, rt_pend, out_ready,
        output in_ready, out_valid, out_pc, out_taken, out_target,
        output redirect, redirect_pc
    );
endinterface

// File: rtl/branch_resolve.sv
// ---------------------------------------------------------------------------
// branch_resolve
// Decode-stage BEQ/BNE resolution. A decoded instruction is captured; if it is
// a branch with an operand still pending, the block waits (re-sampling the
// live operands) until both are available. The outcome (taken, target) is
// registered and held for the next stage; a taken branch raises a one-cycle
// redirect to fetch on the first cycle the result is held.
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous active-high reset
//   bus    branch_resolve_if.slave (decode, operands, next stage, redirect)
//   stat_taken / stat_not_taken  [31:0] resolved-branch counters, present only
//          when BRANCH_RESOLVE_STATS_EN is defined
// Configuration macro: BRANCH_RESOLVE_STATS_EN (undefined by default).
// Also contains equality_check, the operand comparator used for resolution.
// ---------------------------------------------------------------------------
module equality_check #(
    parameter int N = 32
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         eq,
    output logic         neq
);
    assign eq  = (a == b);
    assign neq = (a != b);
endmodule

module branch_resolve #(
    parameter int N   = 32,
    parameter int PCW = 32
) (
    input  logic clk,
    input  logic reset,
    branch_resolve_if.slave bus
`ifdef BRANCH_RESOLVE_STATS_EN
    ,
    output logic [31:0] stat_taken,
    output logic [31:0] stat_not_taken
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic                  in_ready;
    logic                  capture;
    logic                  resolve;
    logic                  use_held;
    logic                  ops_eq;
    logic                  ops_neq;
    logic                  operands_pend;

    // Captured instruction, used while waiting on operands
    logic [1:0]            op_p0;
    logic [PCW-1:0]        pc_p0;
    logic signed [15:0]    imm_p0;

    // Registered outcome
    logic [PCW-1:0]        out_pc_p1;
    logic                  taken_p1;
    logic [PCW-1:0]        target_p1;
    logic                  redirect_p1;

    logic [1:0]            op_sel;
    logic [PCW-1:0]        pc_sel;
    logic signed [15:0]    imm_sel;
    logic                  taken_sel;
    logic [PCW-1:0]        target_sel;

    function automatic logic is_branch(input logic [1:0] op);
        return (op == 2'b01) || (op == 2'b10);
    endfunction

    function automatic logic calc_taken(input logic [1:0] op, input logic eq, input logic neq);
        return ((op == 2'b01) && eq) || ((op == 2'b10) && neq);
    endfunction

    // pc + 4 + (sext(imm) << 2), wrapping modulo 2^PCW
    function automatic logic [PCW-1:0] calc_target(input logic [PCW-1:0] pc,
                                                   input logic signed [15:0] imm);
        logic signed [PCW+15:0] off;
        off = {{PCW{imm[15]}}, imm};
        off = off <<< 2;
        return pc + PCW'(32'd4) + off[PCW-1:0];
    endfunction

    equality_check #(.N(N)) u_eq (
        .a   (bus.rs_val),
        .b   (bus.rt_val),
        .eq  (ops_eq),
        .neq (ops_neq)
    );

    assign operands_pend = bus.rs_pend || bus.rt_pend;

    // Resolution uses the live decode fields on the accept edge, the captured
    // ones when leaving WAIT. Operands are always the live values.
    assign op_sel     = use_held ? op_p0  : bus.in_op;
    assign pc_sel     = use_held ? pc_p0  : bus.in_pc;
    assign imm_sel    = use_held ? imm_p0 : bus.in_imm;
    assign taken_sel  = calc_taken(op_sel, ops_eq, ops_neq);
    assign target_sel = calc_target(pc_sel, imm_sel);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        capture   = 1'b0;
        resolve   = 1'b0;
        use_held  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (bus.in_valid) begin
                    capture = 1'b1;
                    if (is_branch(bus.in_op) && operands_pend) begin
                        state_nxt = WAIT;
                    end else begin
                        resolve   = 1'b1;
                        state_nxt = HOLD;
                    end
                end
            end
            WAIT: begin
                if (!operands_pend) begin
                    resolve   = 1'b1;
                    use_held  = 1'b1;
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                // Accepting while the result leaves gives one instruction per cycle
                in_ready = bus.out_ready;
                if (bus.out_ready) begin
                    if (bus.in_valid) begin
                        capture = 1'b1;
                        if (is_branch(bus.in_op) && operands_pend) begin
                            state_nxt = WAIT;
                        end else begin
                            resolve   = 1'b1;
                            state_nxt = HOLD;
                        end
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
        // flush drops both the held instruction and any same-cycle input
        if (bus.flush) begin
            state_nxt = IDLE;
            capture   = 1'b0;
            resolve   = 1'b0;
        end
    end

    // Stage 0: capture decoded instruction
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_p0  <= 2'b00;
            pc_p0  <= '0;
            imm_p0 <= '0;
        end else if (capture) begin
            op_p0  <= bus.in_op;
            pc_p0  <= bus.in_pc;
            imm_p0 <= bus.in_imm;
        end
    end

    // Stage 1: registered outcome; redirect is a pulse set only by a resolve
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_pc_p1   <= '0;
            taken_p1    <= 1'b0;
            target_p1   <= '0;
            redirect_p1 <= 1'b0;
        end else begin
            if (resolve) begin
                out_pc_p1 <= pc_sel;
                taken_p1  <= taken_sel;
                target_p1 <= target_sel;
            end
            redirect_p1 <= resolve && taken_sel;
        end
    end

`ifdef BRANCH_RESOLVE_STATS_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stat_taken     <= '0;
            stat_not_taken <= '0;
        end else if (resolve && is_branch(op_sel)) begin
            if (taken_sel) begin
                stat_taken <= stat_taken + 32'd1;
            end else begin
                stat_not_taken <= stat_not_taken + 32'd1;
            end
        end
    end
`endif

    assign bus.in_ready    = in_ready;
    assign bus.out_valid   = (state == HOLD);
    assign bus.out_pc      = out_pc_p1;
    assign bus.out_taken   = taken_p1;
    assign bus.out_target  = target_p1;
    assign bus.redirect    = redirect_p1;
    assign bus.redirect_pc = target_p1;

endmodule
